// File: rtl/pipe_pkg.sv
// Shared field layout for the MIPS inter-stage registers and the skid-stage state encoding.
package pipe_pkg;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_JUMP     = 5;
  localparam int CTRL_ALUZERO  = 6;
  localparam int CTRL_SPARE    = 7;
  localparam int CTRL_BUNDLE_W = 8;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  // EX/MEM data bundle: {target, write data, ALU result, regRd}
  localparam int EXMEM_DATA_W = REG_W + 3 * WORD_W;
  localparam int OFF_REGRD    = 0;
  localparam int OFF_ALU      = OFF_REGRD + REG_W;
  localparam int OFF_WDATA    = OFF_ALU + WORD_W;
  localparam int OFF_TARGET   = OFF_WDATA + WORD_W;

  // Encoded as {s_valid, m_valid}; 2'b10 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, ctrl, data} holding register with load and clear; clear wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = CTRL_BUNDLE_W,
  parameter int DATA_W    = EXMEM_DATA_W,
  parameter bit ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
    end
  end

  // Data is always zeroed by reset; on clear only when ZERO_DATA is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      if (ZERO_DATA) data <= '0;
    end else if (load) begin
      data <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flush-to-bubble.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = CTRL_BUNDLE_W,
  parameter int DATA_W    = EXMEM_DATA_W,
  parameter bit ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ld_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_ld_data;
  logic              m_load, m_clr, s_load, s_clr, m_from_skid;
  logic              accept, send;
  skid_state_t       state;

  assign state  = skid_state_t'({s_valid, m_valid});
  assign accept = in_valid & in_ready;
  assign send   = m_valid & out_ready;

  always_comb begin
    m_load      = 1'b0;
    m_clr       = 1'b0;
    s_load      = 1'b0;
    s_clr       = 1'b0;
    m_from_skid = 1'b0;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: m_load = accept;
        ST_ONE: begin
          if (accept && send)  m_load = 1'b1;
          else if (accept)     s_load = 1'b1;
          else if (send)       m_clr  = 1'b1;
        end
        ST_FULL: begin
          if (send) begin
            m_load      = 1'b1;
            m_from_skid = 1'b1;
            s_clr       = 1'b1;
          end
        end
        default: begin
          m_clr = 1'b1;
          s_clr = 1'b1;
        end
      endcase
    end
  end

  // Main refills from the skid when draining FULL, otherwise from upstream.
  assign m_ld_ctrl = m_from_skid ? s_ctrl : in_ctrl;
  assign m_ld_data = m_from_skid ? s_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA(ZERO_DATA)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (m_load),
    .clear   (m_clr),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA(ZERO_DATA)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (s_load),
    .clear   (s_clr),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (s_valid),
    .ctrl    (s_ctrl),
    .data    (s_data)
  );

  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule
